// File: rtl/divsqrt_req_queue_pkg.sv
// Shared types for the divide/sqrt request queue: op kinds, operand bundle, queued request.
package divsqrt_req_queue_pkg;

    localparam int TAGW    = 3;
    localparam int XLEN    = 64;
    localparam int NF      = 52;
    localparam int NE      = 11;
    localparam int FMTBITS = 2;

    typedef enum logic [1:0] {
        FDIV  = 2'd0,
        FSQRT = 2'd1,
        IDIV  = 2'd2
    } divop_e;

    typedef struct packed {
        logic [FMTBITS-1:0] Fmt;
        logic               Xs;
        logic [NF:0]        Xm;
        logic [NF:0]        Ym;
        logic [NE-1:0]      Xe;
        logic [NE-1:0]      Ye;
        logic               XInf;
        logic               YInf;
        logic               XZero;
        logic               YZero;
        logic               XNaN;
        logic               YNaN;
        logic [XLEN-1:0]    SrcA;
        logic [XLEN-1:0]    SrcB;
        logic [2:0]         Funct3;
    } divop_t;

    typedef struct packed {
        divop_e            Op;
        divop_t            Ops;
        logic              W64;
        logic [TAGW-1:0]   Tag;
    } divreq_t;

    // Anything that is not an integer op goes to the FP start strobe.
    function automatic logic is_int_op(input divop_e op);
        return op == IDIV;
    endfunction

endpackage

// File: rtl/divsqrt_req_queue_fifo.sv
// Generic DEPTH-entry circular FIFO with flush; push is ignored when full, pop when empty.
module divsqrt_req_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [W-1:0]           wdata_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [W-1:0]           head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) tail_d = tail_q + 1'b1;
            if (pop_ok)  head_d = head_q + 1'b1;
            count_d = count_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[tail_q] <= wdata_i;
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/divsqrt_req_queue.sv
// Request queue in front of the shared divider: buffers requests, launches one at a time, returns tags.
module divsqrt_req_queue
    import divsqrt_req_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ReqValid,
    output logic                   ReqReady,
    input  divreq_t                Req,
    input  logic                   FDivBusyE,
    input  logic                   FDivDoneE,
    input  logic                   StallM,
    input  logic                   FlushE,
    output logic                   FDivStartE,
    output logic                   IDivStartE,
    output logic                   SqrtE,
    output logic                   IntDivE,
    output logic                   W64E,
    output divop_t                 LaunchOp,
    output logic                   DoneValid,
    output logic [TAGW-1:0]        DoneTag,
    output logic [$clog2(DEPTH):0] Count
);
    localparam int RW = $bits(divreq_t);

    logic [RW-1:0]   head_bits;
    divreq_t         head, head_vis;
    logic            full, empty;
    logic            push, launch, done;
    logic            in_flight_q, in_flight_d;
    logic [TAGW-1:0] tag_q, tag_d;

    assign ReqReady = ~full;
    assign push     = ReqValid & ReqReady & ~FlushE;
    assign launch   = ~empty & ~in_flight_q & ~FDivBusyE & ~FlushE;
    assign done     = FDivDoneE & in_flight_q & ~StallM & ~FlushE;

    divsqrt_req_fifo #(
        .DEPTH (DEPTH),
        .W     (RW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .wdata_i (Req),
        .pop_i   (launch),
        .flush_i (FlushE),
        .head_o  (head_bits),
        .count_o (Count),
        .full_o  (full),
        .empty_o (empty)
    );

    // The storage is never reset, so the head is masked while the queue is empty.
    assign head     = head_bits;
    assign head_vis = empty ? '0 : head;

    assign FDivStartE = launch & ~is_int_op(head.Op);
    assign IDivStartE = launch & is_int_op(head.Op);
    assign SqrtE      = head_vis.Op == FSQRT;
    assign IntDivE    = head_vis.Op == IDIV;
    assign W64E       = head_vis.W64;
    assign LaunchOp   = head_vis.Ops;
    assign DoneValid  = done;
    assign DoneTag    = done ? tag_q : '0;

    always_comb begin
        in_flight_d = in_flight_q;
        tag_d       = tag_q;
        if (FlushE) begin
            in_flight_d = 1'b0;
        end else if (launch) begin
            in_flight_d = 1'b1;
            tag_d       = head.Tag;
        end else if (done) begin
            in_flight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_flight_q <= 1'b0;
            tag_q       <= '0;
        end else begin
            in_flight_q <= in_flight_d;
            tag_q       <= tag_d;
        end
    end

endmodule

// File: tb/tb_divsqrt_req_queue.sv
// Bench for divsqrt_req_queue: directed cycle table, async reset mid-operation, random run against a queue model.
module tb_divsqrt_req_queue;
    import divsqrt_req_queue_pkg::*;

    localparam int DEPTH = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   ReqValid;
    logic                   ReqReady;
    divreq_t                Req;
    logic                   FDivBusyE, FDivDoneE, StallM, FlushE;
    logic                   FDivStartE, IDivStartE, SqrtE, IntDivE, W64E;
    divop_t                 LaunchOp;
    logic                   DoneValid;
    logic [TAGW-1:0]        DoneTag;
    logic [$clog2(DEPTH):0] Count;

    int n_pass  = 0;
    int n_total = 0;

    divsqrt_req_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .ReqValid   (ReqValid),
        .ReqReady   (ReqReady),
        .Req        (Req),
        .FDivBusyE  (FDivBusyE),
        .FDivDoneE  (FDivDoneE),
        .StallM     (StallM),
        .FlushE     (FlushE),
        .FDivStartE (FDivStartE),
        .IDivStartE (IDivStartE),
        .SqrtE      (SqrtE),
        .IntDivE    (IntDivE),
        .W64E       (W64E),
        .LaunchOp   (LaunchOp),
        .DoneValid  (DoneValid),
        .DoneTag    (DoneTag),
        .Count      (Count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_op(input string name, input divop_t act, input divop_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic divop_t mk_op(input int tag);
        divop_t      o;
        logic [63:0] s;
        s        = 64'(tag) * 64'h0123_4567_89ab_cdef;
        o.Fmt    = 2'(tag);
        o.Xs     = s[0];
        o.Xm     = s[52:0];
        o.Ym     = ~s[63:11];
        o.Xe     = s[10:0];
        o.Ye     = s[21:11];
        {o.XInf, o.YInf, o.XZero, o.YZero, o.XNaN, o.YNaN} = s[27:22];
        o.SrcA   = s;
        o.SrcB   = ~s;
        o.Funct3 = 3'(tag + 3);
        return o;
    endfunction

    function automatic divreq_t mk_req(input divop_e op, input int tag);
        divreq_t r;
        r.Op  = op;
        r.Ops = mk_op(tag);
        r.W64 = (op == IDIV);
        r.Tag = TAGW'(tag);
        return r;
    endfunction

    function automatic divreq_t rnd_req();
        logic [287:0] bits;
        divreq_t      r;
        for (int i = 0; i < 9; i++) bits[i*32 +: 32] = $urandom;
        r    = divreq_t'(bits[$bits(divreq_t)-1:0]);
        r.Op = divop_e'(2'($urandom_range(0, 2)));
        return r;
    endfunction

    task automatic drive(input logic vld, input divreq_t r, input logic busy,
                         input logic dn, input logic stall, input logic flush);
        ReqValid  = vld;
        Req       = r;
        FDivBusyE = busy;
        FDivDoneE = dn;
        StallM    = stall;
        FlushE    = flush;
    endtask

    // One directed cycle: inputs plus every expected output (e_head < 0 means LaunchOp reads 0).
    typedef struct {
        int     vld;
        divop_e op;
        int     tag;
        int     busy, dn, stall, flush;
        int     e_rdy, e_fs, e_is, e_sq, e_id, e_dv, e_dtag, e_cnt, e_head;
    } vec_t;

    vec_t tbl[22];

    task automatic check_row(input int i, input vec_t t);
        divop_t eop;
        eop = (t.e_head < 0) ? divop_t'('0) : mk_op(t.e_head);
        chk($sformatf("row%0d ready", i),   64'(ReqReady),   64'(t.e_rdy));
        chk($sformatf("row%0d fstart", i),  64'(FDivStartE), 64'(t.e_fs));
        chk($sformatf("row%0d istart", i),  64'(IDivStartE), 64'(t.e_is));
        chk($sformatf("row%0d sqrt", i),    64'(SqrtE),      64'(t.e_sq));
        chk($sformatf("row%0d intdiv", i),  64'(IntDivE),    64'(t.e_id));
        chk($sformatf("row%0d w64", i),     64'(W64E),       64'(t.e_id));
        chk($sformatf("row%0d dvalid", i),  64'(DoneValid),  64'(t.e_dv));
        chk($sformatf("row%0d dtag", i),    64'(DoneTag),    64'(t.e_dtag));
        chk($sformatf("row%0d count", i),   64'(Count),      64'(t.e_cnt));
        chk_op($sformatf("row%0d launchop", i), LaunchOp, eop);
    endtask

    // Reference model: a plain FIFO of requests plus one in-flight slot.
    divreq_t         mdl_q[$];
    logic            mdl_busy;
    logic [TAGW-1:0] mdl_tag;

    task automatic model_cycle(input int cyc);
        int      sz;
        logic    launch, dn, push;
        divreq_t h, popped;
        sz     = mdl_q.size();
        h      = (sz != 0) ? mdl_q[0] : divreq_t'('0);
        launch = (sz != 0) && !mdl_busy && !FDivBusyE && !FlushE;
        dn     = FDivDoneE && mdl_busy && !StallM && !FlushE;
        push   = ReqValid && (sz < DEPTH) && !FlushE;
        chk($sformatf("rnd%0d ready", cyc),  64'(ReqReady),   64'(sz < DEPTH));
        chk($sformatf("rnd%0d fstart", cyc), 64'(FDivStartE), 64'(launch && h.Op != IDIV));
        chk($sformatf("rnd%0d istart", cyc), 64'(IDivStartE), 64'(launch && h.Op == IDIV));
        chk($sformatf("rnd%0d sqrt", cyc),   64'(SqrtE),      64'(sz != 0 && h.Op == FSQRT));
        chk($sformatf("rnd%0d intdiv", cyc), 64'(IntDivE),    64'(sz != 0 && h.Op == IDIV));
        chk($sformatf("rnd%0d w64", cyc),    64'(W64E),       64'(h.W64));
        chk($sformatf("rnd%0d dvalid", cyc), 64'(DoneValid),  64'(dn));
        chk($sformatf("rnd%0d dtag", cyc),   64'(DoneTag),    dn ? 64'(mdl_tag) : 64'd0);
        chk($sformatf("rnd%0d count", cyc),  64'(Count),      64'(sz));
        chk_op($sformatf("rnd%0d launchop", cyc), LaunchOp, h.Ops);
        if (FlushE) begin
            mdl_q.delete();
            mdl_busy = 1'b0;
        end else begin
            if (dn) mdl_busy = 1'b0;
            if (launch) begin
                popped   = mdl_q.pop_front();
                mdl_tag  = popped.Tag;
                mdl_busy = 1'b1;
            end
            if (push) mdl_q.push_back(Req);
        end
    endtask

    initial begin
        //            vld op     tag busy dn stall flush | rdy fs is sq id dv dtag cnt head
        tbl[0]  = '{0, FDIV,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, -1};
        tbl[1]  = '{1, IDIV,  1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, -1};
        tbl[2]  = '{1, FSQRT, 2, 0, 0, 0, 0,  1, 0, 1, 0, 1, 0, 0, 1,  1};
        tbl[3]  = '{0, FDIV,  0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 1,  2};
        tbl[4]  = '{0, FDIV,  0, 1, 1, 0, 0,  1, 0, 0, 1, 0, 1, 1, 1,  2};
        tbl[5]  = '{0, FDIV,  0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0, 0, 1,  2};
        tbl[6]  = '{0, FDIV,  0, 0, 1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, -1};
        tbl[7]  = '{0, FDIV,  0, 0, 1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, -1};
        tbl[8]  = '{0, FDIV,  0, 0, 1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, -1};
        tbl[9]  = '{0, FDIV,  0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 1, 2, 0, -1};
        tbl[10] = '{1, FDIV,  3, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, -1};
        tbl[11] = '{1, FDIV,  4, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 1,  3};
        tbl[12] = '{1, FDIV,  5, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 2,  3};
        tbl[13] = '{1, FDIV,  5, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 2,  3};
        tbl[14] = '{1, FDIV,  5, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 1,  4};
        tbl[15] = '{0, FDIV,  0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1, 3, 2,  4};
        tbl[16] = '{0, FDIV,  0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 2,  4};
        tbl[17] = '{0, FDIV,  0, 0, 1, 0, 1,  1, 0, 0, 0, 0, 0, 0, 1,  5};
        tbl[18] = '{0, FDIV,  0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, -1};
        tbl[19] = '{1, FDIV,  6, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, -1};
        tbl[20] = '{0, FDIV,  0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 1,  6};
        tbl[21] = '{0, FDIV,  0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 1, 6, 0, -1};

        // Reset state
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        chk("reset count",  64'(Count),      64'd0);
        chk("reset ready",  64'(ReqReady),   64'd1);
        chk("reset fstart", 64'(FDivStartE), 64'd0);
        chk("reset dvalid", 64'(DoneValid),  64'd0);
        chk_op("reset launchop", LaunchOp, '0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Directed table
        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i].vld != 0, mk_req(tbl[i].op, tbl[i].tag), tbl[i].busy != 0,
                  tbl[i].dn != 0, tbl[i].stall != 0, tbl[i].flush != 0);
            @(negedge clk);
            check_row(i, tbl[i]);
        end

        // Async reset with two queued and one in flight
        @(posedge clk); #1;
        drive(1'b1, mk_req(FDIV, 1), 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, mk_req(IDIV, 2), 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, mk_req(FSQRT, 3), 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        chk("prerst count",  64'(Count),     64'd2);
        chk("prerst dvalid", 64'(DoneValid), 64'd1);
        chk("prerst dtag",   64'(DoneTag),   64'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst count",  64'(Count),      64'd0);
        chk("midrst ready",  64'(ReqReady),   64'd1);
        chk("midrst fstart", 64'(FDivStartE), 64'd0);
        chk("midrst istart", 64'(IDivStartE), 64'd0);
        chk("midrst dvalid", 64'(DoneValid),  64'd0);
        chk("midrst dtag",   64'(DoneTag),    64'd0);
        chk("midrst intdiv", 64'(IntDivE),    64'd0);
        chk_op("midrst launchop", LaunchOp, '0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Random run against the model
        mdl_busy = 1'b0;
        mdl_tag  = '0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            drive($urandom_range(0, 1) == 1, rnd_req(), $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 24) == 0);
            @(negedge clk);
            model_cycle(c);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/divsqrt_req_queue.md
Name: divsqrt_req_queue

Overview:
- Request queue and launch sequencer directly upstream of the combined FP divide/sqrt and integer div/rem unit.
- Buffers up to DEPTH decoded requests (FP div, FP sqrt, integer div/rem) from the issue side.
- Launches one request at a time when the divider is idle, driving its start strobes and operand fields.
- Tracks the single in-flight operation and returns its tag when the divider reports done.

Parameters:
- DEPTH, 2, queue entries (power of two, >=2)
- TAGW, 3, request tag width
- XLEN, 64, integer operand width
- NF, 52, widest FP fraction width
- NE, 11, widest FP exponent width
- FMTBITS, 2, FP format field width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ReqValid  in  1  request offered
- ReqReady  out  1  queue can accept (count < DEPTH)
- Req  in  divreq_t  op kind, Fmt, Xs, Xm, Ym, Xe, Ye, X/Y Inf/Zero/NaN flags, SrcA, SrcB, Funct3, W64, Tag
- FDivBusyE  in  1  divider busy
- FDivDoneE  in  1  divider result available
- StallM  in  1  M-stage stall
- FlushE  in  1  flush
- FDivStartE  out  1  FP div/sqrt start pulse
- IDivStartE  out  1  integer div/rem start pulse
- SqrtE, IntDivE, W64E  out  1 each  decoded op of head entry
- LaunchOp  out  divop_t  head-entry operand fields (Fmt, Xs, Xm, Ym, Xe, Ye, flags, SrcA, SrcB, Funct3)
- DoneValid  out  1  one-cycle completion pulse
- DoneTag  out  TAGW  tag of completed op
- Count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (reset=0, async): pointers=0, Count=0, InFlight=0; all start/done outputs 0; LaunchOp, DoneTag=0.
- Storage: circular buffer; head/tail pointers wrap at DEPTH.
- ReqReady = (Count != DEPTH), purely registered-state based. No push-through-when-full even if a pop occurs in the same cycle.
- Push: ReqValid & ReqReady & !FlushE writes Req at tail; tail++; Count++.
- Launch condition: Count!=0 & !InFlight & !FDivBusyE & !FlushE.
  - Asserts exactly one of FDivStartE (op FDIV/FSQRT) or IDivStartE (op IDIV) for one cycle.
  - Pops head; sets InFlight; captures InFlightTag.
- LaunchOp, SqrtE, IntDivE, W64E are driven combinationally from the head entry. When Count=0 they read 0.
- Latency: a push into an empty, idle queue launches no earlier than the next cycle (entry must be registered). Push and launch in the same cycle both take effect: Count is unchanged, and the launched entry is the old head.
- Completion: FDivDoneE & InFlight & !StallM & !FlushE.
  - DoneValid=1 and DoneTag=InFlightTag for one cycle; InFlight cleared.
  - Under StallM, completion is deferred. Each cycle FDivDoneE holds while stalled, DoneValid stays 0; the done is taken on the first unstalled cycle.
- No launch in the same cycle as completion: InFlight is registered, so the next launch is at least one cycle after DoneValid.
- FDivDoneE with !InFlight is ignored.
- FlushE: clears Count, pointers and InFlight at the next edge. No push, launch or DoneValid in that cycle.
- Back-to-back: the divider runs one op at a time; queue order is strictly FIFO. Integer and FP ops are not reordered.

Decomposition:
- Shared package holds:
  - divop_e enum {FDIV, FSQRT, IDIV}
  - divop_t packed operand struct
  - divreq_t = {divop_e, divop_t, Tag}
- One sub-module is natural: divsqrt_req_fifo, a generic DEPTH-entry synchronous FIFO with async active-low reset, push/pop/count/flush.
- Launch and in-flight tracking stay in the top module.

Test Plan:
- Reset mid-operation: two entries queued, one in flight; drive reset=0 between edges → Count=0, InFlight=0, ReqReady=1, all pulses 0 immediately.
- Single FDIV, Tag=5, empty queue, FDivBusyE=0 → FDivStartE at cycle+1 with Xm/Ym of request; FDivDoneE later → DoneValid=1, DoneTag=5 for exactly one cycle.
- Full queue: push Tags 1,2,3 with FDivBusyE=1, DEPTH=2 → ReqReady=0 after 2 pushes, Tag 3 held off. Drop busy → Tag1 launches; Tag3 accepted the following cycle; launch order 1,2,3.
- Mixed ops: IDIV (Funct3=100, W64=1) then FSQRT → IDivStartE pulses first with IntDivE=1; after done, FDivStartE with SqrtE=1. Start strobes are never simultaneous.
- Stall at done: FDivDoneE=1 while StallM=1 for 3 cycles → DoneValid=0; StallM drops → DoneValid=1 once; next launch 1 cycle later.
- Flush with 2 queued and 1 in flight → Count=0 next cycle; no DoneValid even if FDivDoneE arrives afterward; a new push launches normally.
